// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle integer/bit ops plus iterative MUL/MULHU/DIVU/REMU.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for iterative ops.
// Backpressure: result is held in DONE until out_ready; in_ready is high only in IDLE.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       sel,
    input  logic [WIDTH-1:0] number1,
    input  logic [WIDTH-1:0] number2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   alu_out_q;

    logic               div_op, is_iter, last;
    logic [SHW-1:0]     sh;
    logic [SHW:0]       clz, ctz, cpop;
    logic [WIDTH-1:0]   res_single, res_iter;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;

    assign div_op  = (sel == 5'd19) || (sel == 5'd20);
    // divide-by-zero is resolved at acceptance, so it never enters BUSY
    assign is_iter = (sel == 5'd17) || (sel == 5'd18) || (div_op && (number2 != '0));
    assign sh      = number2[SHW-1:0];
    assign last    = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        clz  = (SHW+1)'(WIDTH);
        ctz  = (SHW+1)'(WIDTH);
        cpop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (number1[i]) clz = (SHW+1)'(WIDTH - 1 - i);
            cpop = cpop + (SHW+1)'(number1[i]);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (number1[i]) ctz = (SHW+1)'(i);
        end
    end

    always_comb begin
        res_single = '0;
        case (sel)
            5'd0:  res_single = number1 + number2;
            5'd1:  res_single = number1 - number2;
            5'd2:  res_single = number1 | number2;
            5'd3:  res_single = number1 ^ number2;
            5'd4:  res_single = number1 & number2;
            5'd5:  res_single = number1 << sh;
            5'd6:  res_single = number1 >> sh;
            5'd7:  res_single = $unsigned($signed(number1) >>> sh);
            5'd11: res_single = '0;
            5'd12: res_single = WIDTH'(1);
            5'd13: res_single = number1;
            5'd14: res_single = WIDTH'(clz);
            5'd15: res_single = WIDTH'(ctz);
            5'd16: res_single = WIDTH'(cpop);
            5'd19: res_single = '1;
            5'd20: res_single = number1;
            default: res_single = '0;
        endcase
    end

    // op_q holds sel[1:0]: 01 MUL, 10 MULHU, 11 DIVU, 00 REMU
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, mcand_q};
        if (op_q == 2'b11 || op_q == 2'b00) begin
            if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        case (op_q)
            2'b01:   res_iter = acc_d[WIDTH-1:0];
            2'b10:   res_iter = acc_d[2*WIDTH-1:WIDTH];
            2'b11:   res_iter = acc_d[WIDTH-1:0];
            default: res_iter = acc_d[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = is_iter ? BUSY : DONE;
            end
            BUSY: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            alu_out_q <= '0;
        end else if (!flush) begin
            if (state_q == IDLE && in_valid) begin
                if (is_iter) begin
                    op_q    <= sel[1:0];
                    mcand_q <= number2;
                    acc_q   <= {{WIDTH{1'b0}}, number1};
                    cnt_q   <= '0;
                end else begin
                    alu_out_q <= res_single;
                end
            end else if (state_q == BUSY) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + SHW'(1);
                if (last) alu_out_q <= res_iter;
            end
        end
    end

    assign alu_out = alu_out_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=32 and WIDTH=8 with queue-based scoreboards.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [4:0]  sel;
    logic [31:0] number1, number2;
    logic        in_ready, out_valid, busy;
    logic [31:0] alu_out;

    logic        in_valid8, flush8, out_ready8;
    logic [4:0]  sel8;
    logic [7:0]  n1_8, n2_8;
    logic        in_ready8, out_valid8, busy8;
    logic [7:0]  alu_out8;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .number1(number1), .number2(number2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .sel(sel8), .number1(n1_8), .number2(n2_8), .flush(flush8),
        .out_valid(out_valid8), .out_ready(out_ready8), .alu_out(alu_out8), .busy(busy8)
    );

    typedef struct packed {
        logic [31:0] val;
        logic [15:0] lat;
        logic [15:0] bsy;
        logic [31:0] acyc;
    } exp_t;

    exp_t        q[$], q8[$];
    string       qn[$], qn8[$];
    exp_t        e, e8;
    int          passed = 0, total = 0, cyc = 0;
    int          bcnt = 0, bcnt8 = 0;
    bit          was_v = 1'b0, was_v8 = 1'b0;
    logic [31:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    endtask

    // Scoreboard monitor, 32-bit instance
    always @(negedge clk) begin
        if (!rst_n) begin
            was_v = 1'b0;
            bcnt  = 0;
        end else begin
            if (in_ready) bcnt = 0;
            else if (busy) bcnt++;
            if (out_valid && !was_v) begin
                if (q.size() == 0) check("spurious_out_valid", out_valid, 0);
                else begin
                    e = q[0];
                    check({qn[0], "_lat"}, cyc - e.acyc + 1, e.lat);
                    check({qn[0], "_busy"}, bcnt, e.bsy);
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                check({qn.pop_front(), "_val"}, alu_out, e.val);
            end
            was_v = out_valid;
        end
    end

    // Scoreboard monitor, 8-bit instance
    always @(negedge clk) begin
        if (!rst_n) begin
            was_v8 = 1'b0;
            bcnt8  = 0;
        end else begin
            if (in_ready8) bcnt8 = 0;
            else if (busy8) bcnt8++;
            if (out_valid8 && !was_v8) begin
                if (q8.size() == 0) check("spurious_out_valid8", out_valid8, 0);
                else begin
                    e8 = q8[0];
                    check({qn8[0], "_lat"}, cyc - e8.acyc + 1, e8.lat);
                    check({qn8[0], "_busy"}, bcnt8, e8.bsy);
                end
            end
            if (out_valid8 && out_ready8 && q8.size() != 0) begin
                e8 = q8.pop_front();
                check({qn8.pop_front(), "_val"}, alu_out8, e8.val);
            end
            was_v8 = out_valid8;
        end
    end

    task automatic issue(input bit w8, input string nm, input logic [4:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                         input int lat, input int bsy, input bit push);
        int   n = 0;
        exp_t x;
        @(negedge clk);
        if (w8) begin sel8 = s; n1_8 = a[7:0]; n2_8 = b[7:0]; in_valid8 = 1'b1; end
        else    begin sel = s; number1 = a; number2 = b; in_valid = 1'b1; end
        while (!(w8 ? in_ready8 : in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_accept"}, w8 ? in_ready8 : in_ready, 1);
        @(posedge clk);
        #1;
        // scramble inputs after the accept edge; the result must not depend on them
        if (w8) begin in_valid8 = 1'b0; sel8 = 5'd0; n1_8 = ~a[7:0]; n2_8 = ~b[7:0]; end
        else    begin in_valid = 1'b0; sel = 5'd0; number1 = ~a; number2 = ~b; end
        if (push) begin
            x.val  = expv;
            x.lat  = 16'(lat);
            x.bsy  = 16'(bsy);
            x.acyc = 32'(cyc);
            if (w8) begin q8.push_back(x); qn8.push_back(nm); end
            else    begin q.push_back(x); qn.push_back(nm); last_exp = expv; end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q8.size() != 0 || !in_ready || !in_ready8) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size() + q8.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        sel = '0; number1 = '0; number2 = '0;
        in_valid8 = 1'b0; flush8 = 1'b0; out_ready8 = 1'b1;
        sel8 = '0; n1_8 = '0; n2_8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_alu_out8", alu_out8, 0);
        rst_n = 1'b1;

        // single-cycle ops, issued back to back
        issue(0, "add_wrap", 5'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 1);
        issue(0, "sub",      5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1, 0, 1);
        issue(0, "or",       5'd2,  32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1, 0, 1);
        issue(0, "xor",      5'd3,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1, 0, 1);
        issue(0, "and",      5'd4,  32'h12345678, 32'h0000FFFF, 32'h00005678, 1, 0, 1);
        issue(0, "sll",      5'd5,  32'h1,        32'h24,       32'h10,       1, 0, 1);
        issue(0, "srl",      5'd6,  32'h80000000, 32'd31,       32'h1,        1, 0, 1);
        issue(0, "sra",      5'd7,  32'h80000000, 32'h21,       32'hC0000000, 1, 0, 1);
        issue(0, "const0",   5'd11, 32'h55,       32'h66,       32'h0,        1, 0, 1);
        issue(0, "const1",   5'd12, 32'h55,       32'h66,       32'h1,        1, 0, 1);
        issue(0, "pass",     5'd13, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1, 0, 1);
        issue(0, "clz_zero", 5'd14, 32'h0,        32'h0,        32'd32,       1, 0, 1);
        issue(0, "clz_b16",  5'd14, 32'h00010000, 32'h0,        32'd15,       1, 0, 1);
        issue(0, "ctz_b16",  5'd15, 32'h00010000, 32'h0,        32'd16,       1, 0, 1);
        issue(0, "ctz_zero", 5'd15, 32'h0,        32'h0,        32'd32,       1, 0, 1);
        issue(0, "cpop",     5'd16, 32'hF0F0F0F0, 32'h0,        32'd16,       1, 0, 1);
        issue(0, "cpop_all", 5'd16, 32'hFFFFFFFF, 32'h0,        32'd32,       1, 0, 1);
        issue(0, "undef",    5'd21, 32'hFF,       32'hFF,       32'h0,        1, 0, 1);

        // iterative ops
        issue(0, "mul",      5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 32, 1);
        issue(0, "mulhu",    5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32, 1);
        issue(0, "mul_b",    5'd17, 32'h12345678, 32'h10,       32'h23456780, 33, 32, 1);
        issue(0, "mulhu_b",  5'd18, 32'h12345678, 32'h10,       32'h00000001, 33, 32, 1);
        issue(0, "divu",     5'd19, 32'd100,      32'd7,        32'd14,       33, 32, 1);
        issue(0, "remu",     5'd20, 32'd100,      32'd7,        32'd2,        33, 32, 1);
        issue(0, "divu_big", 5'd19, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33, 32, 1);

        // divide by zero
        issue(0, "divu_z",   5'd19, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 1);
        issue(0, "remu_z",   5'd20, 32'd5,        32'd0,        32'd5,        1, 0, 1);
        drain();

        // backpressure
        @(posedge clk); #1 out_ready = 1'b0;
        issue(0, "mul_bp", 5'd17, 32'd3, 32'd4, 32'd12, 33, 32, 1);
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        check("bp_reach_done", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_alu_out", alu_out, 32'd12);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_out_valid", out_valid, 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // flush mid-DIVU
        issue(0, "divu_flush", 5'd19, 32'd1000, 32'd3, 32'd0, 0, 0, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_alu_out_kept", alu_out, last_exp);
        // flush wins over a simultaneous request
        in_valid = 1'b1; sel = 5'd0; number1 = 32'd9; number2 = 32'd9; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_req_out_valid", out_valid, 0);
        check("flush_vs_req_in_ready", in_ready, 1);
        issue(0, "add_after_flush", 5'd0, 32'd2, 32'd3, 32'd5, 1, 0, 1);
        drain();

        // reset mid-DIVU
        issue(0, "divu_reset", 5'd19, 32'd1000, 32'd3, 32'd0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alu_out", alu_out, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle5_in_ready", in_ready, 1);
        check("idle5_out_valid", out_valid, 0);
        check("idle5_busy", busy, 0);
        check("idle5_alu_out", alu_out, 0);
        issue(0, "add_after_reset", 5'd0, 32'd2, 32'd3, 32'd5, 1, 0, 1);

        // WIDTH=8 instance
        issue(1, "w8_mul",   5'd17, 32'h10, 32'h10, 32'h00, 9, 8, 1);
        issue(1, "w8_mulhu", 5'd18, 32'h10, 32'h10, 32'h01, 9, 8, 1);
        issue(1, "w8_divu",  5'd19, 32'd200, 32'd9, 32'd22, 9, 8, 1);
        issue(1, "w8_remu",  5'd20, 32'd200, 32'd9, 32'd2,  9, 8, 1);
        issue(1, "w8_clz0",  5'd14, 32'h0,  32'h0,  32'd8,  1, 0, 1);
        issue(1, "w8_add",   5'd0,  32'hFF, 32'h2,  32'h1,  1, 0, 1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
